debounce_fsm: RTL and testbench

//  Tick-paced switch debouncer; sits directly downstream of free_run_bin_counter,

---
 rtl/debounce_fsm_pkg.sv | 15 +
 rtl/debounce_fsm_sync_2ff.sv | 34 +++
 rtl/debounce_fsm.sv | 112 +++++++++++
 tb/tb_debounce_fsm.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/debounce_fsm_pkg.sv
// ---------------------------------------------------------------------------
// debounce_fsm_pkg
//   Default build-time settings for the tick-paced switch debouncer.
//   The FSM state encoding is private to debounce_fsm. Only the parameter
//   defaults live here, so a parent block can refer to them by name.
// ---------------------------------------------------------------------------
package debounce_fsm_pkg;

  // Number of consecutive sample ticks the input must stay stable to commit.
  localparam int unsigned DEFAULT_STABLE_TICKS = 3;

  // Width of the tick counter. It must satisfy 2**CW >= STABLE_TICKS.
  localparam int unsigned DEFAULT_CW = 2;

endpackage : debounce_fsm_pkg

// File: rtl/debounce_fsm_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser that brings an asynchronous level into the clk
//   domain. Other input-conditioning blocks can reuse it.
//   The output lags the input by 2 clk.
// Ports
//   clk    in  1  sampling clock, rising edge
//   reset  in  1  asynchronous active-low reset (0 = in reset)
//   d      in  1  asynchronous input level
//   q      out 1  synchronised level
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is updated with non-blocking assignments so that
  // both flops sample their old values on the same edge. Blocking assignments
  // here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/debounce_fsm.sv
// ---------------------------------------------------------------------------
// debounce_fsm
//   Tick-paced debouncer for a mechanical switch. The raw input is first
//   synchronised. The debounced level then changes only after the
//   synchronised input has stayed stable for STABLE_TICKS sample ticks.
//   Each rising commit produces a one-clk pulse on db_tick.
//   The tick source is a free-running counter's max_tick, instantiated by
//   the parent block.
// Ports
//   clk       in  1  system clock, rising edge
//   reset     in  1  asynchronous active-low reset (0 = in reset)
//   tick      in  1  sample strobe; every clk it is high counts as one tick
//   sw        in  1  raw asynchronous switch input
//   db_level  out 1  debounced level, registered
//   db_tick   out 1  one-clk pulse on each debounced 0->1 commit, registered
// ---------------------------------------------------------------------------
module debounce_fsm
  import debounce_fsm_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter int unsigned CW           = DEFAULT_CW
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // The counter value on which the final tick of a stable period lands.
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_TICKS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sw_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  // The outputs are updated together with the state, so db_level and
  // db_tick rise in the first cycle spent in ONE.
  // cnt is cleared on every entry into a WAIT state. It never wraps,
  // because reaching LAST_CNT on a tick always leaves the WAIT state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ZERO;
      cnt      <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      db_tick <= 1'b0;
      case (state)
        ZERO: begin
          if (sw_s) begin
            state <= WAIT1;
            cnt   <= '0;
          end
        end
        WAIT1: begin
          // A bounce back to 0 wins over a tick arriving in the same clk.
          if (!sw_s) begin
            state <= ZERO;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == LAST_CNT) begin
              state    <= ONE;
              db_level <= 1'b1;
              db_tick  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ONE: begin
          if (!sw_s) begin
            state <= WAIT0;
            cnt   <= '0;
          end
        end
        WAIT0: begin
          if (sw_s) begin
            state <= ONE;
          end else if (tick) begin
            if (cnt == LAST_CNT) begin
              state    <= ZERO;
              db_level <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ZERO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : debounce_fsm

// File: tb/tb_debounce_fsm.sv
// ---------------------------------------------------------------------------
// tb_debounce_fsm
//   Directed bench for debounce_fsm with STABLE_TICKS=3 and CW=2.
//   tick is high for one clk and is sampled on edges 8, 16, 24, and so on.
//   A switch change driven just after edge e reaches the FSM at edge e+3.
//   Every time the stimulus issues a change, it pushes the hand-derived
//   output event (edge number, level, pulse) into a queue. The monitor pops
//   one entry each time db_level changes or db_tick is high. An output event
//   that arrives when the queue is empty is reported as a spurious one.
//   While reset is held low, the monitor checks that both outputs are 0.
// ---------------------------------------------------------------------------
module tb_debounce_fsm;

  typedef struct {
    int   edge_no;
    logic level;
    logic pulse;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic sw;
  logic db_level;
  logic db_tick;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  logic prev_level = 1'b0;
  ev_t exp_q[$];

  debounce_fsm #(
    .STABLE_TICKS (3),
    .CW           (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  always #5 clk = ~clk;

  // cyc counts rising edges. tick is set so that it is sampled high on
  // each edge whose number is a multiple of 8.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      tick = ((cyc + 1) % 8 == 0);
    end
  end

  // Returns 2 time units after edge e, so anything driven here is
  // sampled at edge e+1.
  task automatic at_edge(input int e);
    wait (cyc >= e);
    #2;
  endtask

  task automatic expect_ev(input int e, input logic level, input logic pulse);
    ev_t ev;
    ev.edge_no = e;
    ev.level   = level;
    ev.pulse   = pulse;
    exp_q.push_back(ev);
  endtask

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      vectors++;
      if (db_level !== 1'b0 || db_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs edge=%0d: got level=%b tick=%b, want level=0 tick=0",
                 cyc, db_level, db_tick);
      end
      prev_level = 1'b0;
    end else if (db_tick !== 1'b0 || db_level !== prev_level) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_event edge=%0d: got level=%b tick=%b, want no output event",
                 cyc, db_level, db_tick);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        if (cyc != ev.edge_no || db_level !== ev.level || db_tick !== ev.pulse) begin
          miscompares++;
          $display("FAIL output_event: got edge=%0d level=%b tick=%b, want edge=%0d level=%b tick=%b",
                   cyc, db_level, db_tick, ev.edge_no, ev.level, ev.pulse);
        end
      end
      prev_level = db_level;
    end
  end

  initial begin
    // Test 1: reset held with sw=1. Outputs must stay 0 throughout.
    reset = 1'b0;
    sw    = 1'b1;
    at_edge(3);
    sw    = 1'b0;
    reset = 1'b1;

    // Test 2: clean 0->1. The FSM enters WAIT1 at edge 13.
    // Ticks at 16, 24 and 32 give a commit at 32.
    at_edge(10);
    sw = 1'b1;
    expect_ev(32, 1'b1, 1'b1);

    // Test 4: clean 1->0. The FSM enters WAIT0 at edge 43.
    // Ticks at 48, 56 and 64 give a level drop with no pulse.
    at_edge(40);
    sw = 1'b0;
    expect_ev(64, 1'b0, 1'b0);

    // Test 3: bounce every 3 clk, then hold 1.
    // The last entry into WAIT1 is at edge 85. Ticks at 88, 96 and 104
    // give a single commit.
    at_edge(70); sw = 1'b1;
    at_edge(73); sw = 1'b0;
    at_edge(76); sw = 1'b1;
    at_edge(79); sw = 1'b0;
    at_edge(82); sw = 1'b1;
    expect_ev(104, 1'b1, 1'b1);

    // Return to ZERO: the FSM enters WAIT0 at edge 113.
    // Ticks at 120, 128 and 136 drop the level.
    at_edge(110);
    sw = 1'b0;
    expect_ev(136, 1'b0, 1'b0);

    // Test 5: the FSM enters WAIT1 at edge 143 and counts ticks at 144
    // and 152. sw_s drops at edge 160, together with the third tick,
    // so there is no commit.
    // The FSM re-enters WAIT1 at edge 168; the tick on that same edge is
    // ignored. Fresh ticks at 176, 184 and 192 give a commit.
    at_edge(140); sw = 1'b1;
    at_edge(157); sw = 1'b0;
    at_edge(165); sw = 1'b1;
    expect_ev(192, 1'b1, 1'b1);

    // Back to ZERO: the FSM enters WAIT0 at edge 199.
    // Ticks at 200, 208 and 216 drop the level.
    at_edge(196);
    sw = 1'b0;
    expect_ev(216, 1'b0, 1'b0);

    // Test 6: the FSM enters WAIT1 at edge 223 and counts ticks at 224
    // and 232. Reset is then held low through edges 235 and 236.
    // After release, the FSM re-enters WAIT1 at edge 239 and needs fresh
    // ticks at 240, 248 and 256.
    at_edge(220); sw = 1'b1;
    at_edge(234); reset = 1'b0;
    at_edge(236); reset = 1'b1;
    expect_ev(256, 1'b1, 1'b1);

    at_edge(270);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: got %0d expected events never seen, want 0 (next expected edge=%0d)",
               exp_q.size(), exp_q[0].edge_no);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_debounce_fsm
